// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - buffer-to-serializer handshake and serial line bundle
interface uart_tx_serializer_if #(
    parameter int BITWIDTH = 8
);
    logic [BITWIDTH-1:0] tdataIn;
    logic                ttxrdy;
    logic                tparityEn;
    logic                tparityOdd;
    logic                tTxd;
    logic                tBusy;
    logic                tLoad;
    logic                tDone;

    // Buffer side: offers bytes and frame options, observes the serializer.
    modport master (
        output tdataIn, ttxrdy, tparityEn, tparityOdd,
        input  tTxd, tBusy, tLoad, tDone
    );

    // Serializer side.
    modport slave (
        input  tdataIn, ttxrdy, tparityEn, tparityOdd,
        output tTxd, tBusy, tLoad, tDone
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer: start, LSB-first data, optional parity, stop bits
module uart_tx_serializer #(
    parameter int BITWIDTH     = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int NUM_STOP     = 1
) (
    input  logic                  tClk,
    input  logic                  tRst,
    uart_tx_serializer_if.slave   bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int NW = $clog2(BITWIDTH + NUM_STOP + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [NW-1:0]       bitcnt, bitcnt_n;
    logic [BITWIDTH-1:0] shreg, shreg_n;
    logic                par_en, par_en_n;
    logic                par_bit, par_bit_n;
    logic                accept;
    logic                bit_end;

    logic                txd_q, busy_q, load_q, done_q;
    logic                txd_n, busy_n, load_n, done_n;

    assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));

    // State register and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge tClk or posedge tRst) begin
        if (tRst) begin
            state   <= IDLE;
            cnt     <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            par_en  <= 1'b0;
            par_bit <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bitcnt  <= bitcnt_n;
            shreg   <= shreg_n;
            par_en  <= par_en_n;
            par_bit <= par_bit_n;
            txd_q   <= txd_n;
            busy_q  <= busy_n;
            load_q  <= load_n;
            done_q  <= done_n;
        end
    end

    // Next-state: baud counting, bit sequencing, and byte acceptance in IDLE or the last stop cycle.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bitcnt_n  = bitcnt;
        shreg_n   = shreg;
        par_en_n  = par_en;
        par_bit_n = par_bit;
        accept    = 1'b0;

        case (state)
            IDLE: begin
                accept = bus.ttxrdy;
            end
            START: begin
                if (bit_end) begin
                    state_n  = DATA;
                    cnt_n    = '0;
                    bitcnt_n = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    shreg_n = shreg >> 1;
                    if (bitcnt == NW'(BITWIDTH - 1)) begin
                        bitcnt_n = '0;
                        state_n  = par_en ? PARITY : STOP;
                    end else begin
                        bitcnt_n = bitcnt + NW'(1);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n  = STOP;
                    cnt_n    = '0;
                    bitcnt_n = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (bitcnt == NW'(NUM_STOP - 1)) begin
                        if (bus.ttxrdy) begin
                            accept = 1'b1;
                        end else begin
                            state_n  = IDLE;
                            bitcnt_n = '0;
                        end
                    end else begin
                        bitcnt_n = bitcnt + NW'(1);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // Accepting a byte snapshots data and parity options so later input changes cannot leak in.
        if (accept) begin
            state_n   = START;
            cnt_n     = '0;
            bitcnt_n  = '0;
            shreg_n   = bus.tdataIn;
            par_en_n  = bus.tparityEn;
            par_bit_n = (^bus.tdataIn) ^ bus.tparityOdd;
        end
    end

    // Output decode from the upcoming state so every output is a flop with no input-to-output path.
    always_comb begin
        txd_n  = 1'b1;
        busy_n = (state_n != IDLE);
        load_n = accept;
        done_n = (state_n == STOP) && (cnt_n == CW'(CLKS_PER_BIT - 1))
                 && (bitcnt_n == NW'(NUM_STOP - 1));
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shreg_n[0];
            PARITY:  txd_n = par_bit_n;
            default: txd_n = 1'b1;
        endcase
    end

    assign bus.tTxd  = txd_q;
    assign bus.tBusy = busy_q;
    assign bus.tLoad = load_q;
    assign bus.tDone = done_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;
    localparam int CPB = 4;

    logic tClk = 1'b0;
    logic tRst = 1'b0;
    always #5 tClk = ~tClk;

    uart_tx_serializer_if #(.BITWIDTH(8)) bus1 ();
    uart_tx_serializer_if #(.BITWIDTH(8)) bus2 ();

    uart_tx_serializer #(.BITWIDTH(8), .CLKS_PER_BIT(CPB), .NUM_STOP(1)) dut1 (
        .tClk(tClk), .tRst(tRst), .bus(bus1.slave)
    );
    uart_tx_serializer #(.BITWIDTH(8), .CLKS_PER_BIT(CPB), .NUM_STOP(2)) dut2 (
        .tClk(tClk), .tRst(tRst), .bus(bus2.slave)
    );

    int passed = 0;
    int total  = 0;
    bit exp_bits[$];

    typedef struct {
        logic [7:0] data;
        bit         pen;
        bit         podd;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    // Reference: the serial frame as a list of bit values, one entry per bit time.
    task automatic append_frame(input logic [7:0] d, input bit pen, input bit podd, input int ns);
        int ones;
        ones = $countones(d);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        if (pen) exp_bits.push_back(podd ? (ones % 2 == 0) : (ones % 2 == 1));
        for (int i = 0; i < ns; i++) exp_bits.push_back(1'b1);
    endtask

    // Sends one frame on dut1; entered and left just after a rising edge.
    task automatic run_frame(input string tag, input logic [7:0] d, input bit pen,
                             input bit podd, input bit scramble);
        int len, txd_err, busy_err, load_cnt, load_at, done_cnt, done_at;
        exp_bits.delete();
        append_frame(d, pen, podd, 1);
        len = exp_bits.size() * CPB;
        txd_err = 0; busy_err = 0; load_cnt = 0; load_at = 0; done_cnt = 0; done_at = 0;
        bus1.tdataIn = d; bus1.tparityEn = pen; bus1.tparityOdd = podd; bus1.ttxrdy = 1'b1;
        @(posedge tClk); #1;
        bus1.ttxrdy = 1'b0;
        if (scramble) begin
            bus1.tdataIn = 8'($urandom); bus1.tparityEn = ~pen; bus1.tparityOdd = ~podd;
        end
        for (int k = 1; k <= len; k++) begin
            @(negedge tClk);
            if (bus1.tTxd !== exp_bits[(k - 1) / CPB]) txd_err++;
            if (bus1.tBusy !== 1'b1) busy_err++;
            if (bus1.tLoad === 1'b1) begin load_cnt++; load_at = k; end
            if (bus1.tDone === 1'b1) begin done_cnt++; done_at = k; end
            if (scramble && k == len / 2) begin
                bus1.tdataIn = 8'($urandom); bus1.tparityEn = $urandom_range(0, 1);
                bus1.tparityOdd = $urandom_range(0, 1);
            end
        end
        @(negedge tClk);
        check({tag, "_txd"}, txd_err, 0);
        check({tag, "_busy"}, busy_err, 0);
        check({tag, "_load"}, {load_cnt[15:0], load_at[15:0]}, {16'd1, 16'd1});
        check({tag, "_done"}, {done_cnt[15:0], done_at[15:0]}, {16'd1, len[15:0]});
        check({tag, "_idle"}, {bus1.tTxd, bus1.tBusy, bus1.tLoad, bus1.tDone}, 4'b1000);
        @(posedge tClk); #1;
    endtask

    initial begin
        int done_seen, txd_err, load_cnt, load1, load2, done1, done2, done_cnt, len2;
        vecs[0] = '{8'h55, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b0};
        vecs[2] = '{8'h07, 1'b1, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1};
        vecs[5] = '{8'h80, 1'b1, 1'b0};

        bus1.tdataIn = '0; bus1.ttxrdy = 1'b0; bus1.tparityEn = 1'b0; bus1.tparityOdd = 1'b0;
        bus2.tdataIn = '0; bus2.ttxrdy = 1'b0; bus2.tparityEn = 1'b0; bus2.tparityOdd = 1'b0;

        // Reset asserted between clock edges must act immediately.
        #1 tRst = 1'b1;
        #2 check("reset_outputs", {bus1.tTxd, bus1.tBusy, bus1.tLoad, bus1.tDone}, 4'b1000);
        check("reset_outputs2", {bus2.tTxd, bus2.tBusy, bus2.tLoad, bus2.tDone}, 4'b1000);
        #9 tRst = 1'b0;
        @(posedge tClk); #1;

        // Table of directed frames.
        for (int i = 0; i < 6; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].pen, vecs[i].podd, 1'b0);

        // Reset in the middle of data bit 3 of 0x00, then a clean 0xFF frame.
        bus1.tdataIn = 8'h00; bus1.tparityEn = 1'b0; bus1.ttxrdy = 1'b1;
        @(posedge tClk); #1;
        bus1.ttxrdy = 1'b0;
        repeat (18) @(negedge tClk);
        check("pre_reset_txd", bus1.tTxd, 1'b0);
        #2 tRst = 1'b1;
        #1 check("mid_reset", {bus1.tTxd, bus1.tBusy, bus1.tLoad, bus1.tDone}, 4'b1000);
        done_seen = 0;
        repeat (2) begin
            @(negedge tClk);
            if (bus1.tDone === 1'b1) done_seen++;
        end
        @(posedge tClk); #1 tRst = 1'b0;
        repeat (CPB * 12) begin
            @(negedge tClk);
            if (bus1.tDone === 1'b1 || bus1.tTxd !== 1'b1) done_seen++;
        end
        check("no_done_after_abort", done_seen, 0);
        @(posedge tClk); #1;
        run_frame("after_reset", 8'hFF, 1'b0, 1'b0, 1'b0);

        // Randomized frames with inputs disturbed mid-frame.
        for (int i = 0; i < 8; i++)
            run_frame($sformatf("rnd%0d", i), 8'($urandom), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b1);

        // Back-to-back frames on the two-stop-bit instance with ttxrdy held high.
        exp_bits.delete();
        append_frame(8'hA3, 1'b1, 1'b0, 2);
        append_frame(8'h3C, 1'b1, 1'b0, 2);
        len2 = exp_bits.size() * CPB;
        txd_err = 0; load_cnt = 0; load1 = 0; load2 = 0; done_cnt = 0; done1 = 0; done2 = 0;
        bus2.tdataIn = 8'hA3; bus2.tparityEn = 1'b1; bus2.tparityOdd = 1'b0; bus2.ttxrdy = 1'b1;
        @(posedge tClk); #1;
        bus2.tdataIn = 8'h3C;
        for (int k = 1; k <= len2; k++) begin
            @(negedge tClk);
            if (bus2.tTxd !== exp_bits[(k - 1) / CPB]) txd_err++;
            if (bus2.tLoad === 1'b1) begin
                load_cnt++;
                if (load_cnt == 1) load1 = k; else load2 = k;
            end
            if (bus2.tDone === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) done1 = k; else done2 = k;
            end
            if (bus2.tLoad === 1'b1 && k > 1) bus2.ttxrdy = 1'b0;
            if (k == 60) bus2.ttxrdy = 1'b0;
        end
        @(negedge tClk);
        check("b2b_txd", txd_err, 0);
        check("b2b_load_count", load_cnt, 2);
        check("b2b_load_gap", load2 - load1, 48);
        check("b2b_done", {done1[15:0], done2[15:0]}, {16'd48, 16'd96});
        check("b2b_idle", {bus2.tTxd, bus2.tBusy, bus2.tLoad, bus2.tDone}, 4'b1000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
